// File: rtl/wb_stage.sv
// Write-back stage feeding the register file write port. ALU results retire in one
// cycle; loads park in WAIT_MEM until data arrives or the bounded wait expires.
module wb_stage #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_load,
  input  logic [ASIZE-1:0] in_rd,
  input  logic [DSIZE-1:0] in_alu_result,
  input  logic             mem_rvalid,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic             pend_valid,
  output logic [ASIZE-1:0] pend_addr,
  output logic             err
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  state_t           state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [ASIZE-1:0] pend_reg, pend_next;
  logic             err_reg, err_next;
  logic             wen_reg, wen_next;
  logic [ASIZE-1:0] waddr_reg, waddr_next;
  logic [DSIZE-1:0] wdata_reg, wdata_next;
  logic             accept;

  assign in_ready   = (state_reg == IDLE);
  assign accept     = in_valid && in_ready;
  assign pend_valid = (state_reg == WAIT_MEM);
  assign pend_addr  = pend_reg;
  assign err        = err_reg;
  assign wen        = wen_reg;
  assign waddr      = waddr_reg;
  assign wdata      = wdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= '0;
      err_reg   <= 1'b0;
      wen_reg   <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      err_reg   <= err_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    err_next   = err_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            state_next = WAIT_MEM;
            pend_next  = in_rd;
            cnt_next   = '0;
          end else if (in_rd != '0) begin
            wen_next   = 1'b1;
            waddr_next = in_rd;
            wdata_next = in_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        // Arriving data takes priority over an expiring wait.
        if (mem_rvalid) begin
          state_next = IDLE;
          if (pend_reg != '0) begin
            wen_next   = 1'b1;
            waddr_next = pend_reg;
            wdata_next = mem_rdata;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, all checked against
// a cycle-numbered transaction model (load deadline computed as an absolute cycle).
module tb_wb_stage;
  localparam int DSIZE   = 32;
  localparam int ASIZE   = 5;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_is_load;
  logic [ASIZE-1:0] in_rd;
  logic [DSIZE-1:0] in_alu_result;
  logic             mem_rvalid;
  logic [DSIZE-1:0] mem_rdata;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] wdata;
  logic             pend_valid;
  logic [ASIZE-1:0] pend_addr;
  logic             err;

  wb_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wen(wen), .waddr(waddr),
    .wdata(wdata), .pend_valid(pend_valid), .pend_addr(pend_addr), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int writes_seen = 0;

  // Transaction model
  bit               m_wait;
  logic [ASIZE-1:0] m_pa;
  int               m_deadline;
  int               cyc;
  bit               m_err;
  bit               exp_wen;
  logic [ASIZE-1:0] m_waddr;
  logic [DSIZE-1:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_pa = '0; m_deadline = 0; m_err = 0;
    exp_wen = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic check_regs();
    chk("wen", 32'(wen), 32'(exp_wen));
    chk("waddr", 32'(waddr), 32'(m_waddr));
    chk("wdata", wdata, m_wdata);
    chk("err", 32'(err), 32'(m_err));
    if (wen) begin
      writes_seen++;
      $display("[TB] cyc %0d write r%0d <= %08h", cyc, waddr, wdata);
    end
  endtask

  task automatic drive(input bit v, input bit ld, input logic [ASIZE-1:0] rd,
                       input logic [DSIZE-1:0] alu, input bit rv, input logic [DSIZE-1:0] rdata);
    in_valid = v; in_is_load = ld; in_rd = rd; in_alu_result = alu;
    mem_rvalid = rv; mem_rdata = rdata;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_wait));
    chk("pend_valid", 32'(pend_valid), 32'(m_wait));
    chk("pend_addr", 32'(pend_addr), 32'(m_pa));
    exp_wen = 0;
    if (m_wait) begin
      if (rv) begin
        m_wait = 0;
        if (m_pa != '0) begin exp_wen = 1; m_waddr = m_pa; m_wdata = rdata; end
      end else if (cyc == m_deadline) begin
        m_wait = 0; m_err = 1;
      end
    end else if (v) begin
      if (ld) begin
        m_wait = 1; m_pa = rd; m_deadline = cyc + TIMEOUT;
      end else if (rd != '0) begin
        exp_wen = 1; m_waddr = rd; m_wdata = alu;
      end
    end
    @(posedge clk); #1;
    cyc++;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, '0);
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 1; in_is_load = 1; in_rd = 5'd11; in_alu_result = '1;
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    cyc++;
    check_regs();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);
    chk("rst_pend_addr", 32'(pend_addr), 32'd0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    in_valid = 0; in_is_load = 0; in_rd = '0; in_alu_result = '0;
    mem_rvalid = 0; mem_rdata = '0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: back-to-back ALU ops
    drive(1, 0, 5'd3, 32'hA, 0, '0);
    drive(1, 0, 5'd4, 32'hB, 0, '0);
    drive(1, 0, 5'd5, 32'hC, 0, '0);
    idle(1);

    // 2: load rd=7, data four cycles later, then immediate re-accept
    drive(1, 1, 5'd7, 32'h0, 0, '0);
    idle(3);
    drive(0, 0, '0, '0, 1, 32'hDEAD_BEEF);
    drive(1, 0, 5'd8, 32'h88, 0, '0);
    idle(1);

    // 3: rd=0 never writes
    drive(1, 0, 5'd0, 32'h55, 0, '0);
    drive(1, 1, 5'd0, 32'h0, 0, '0);
    idle(1);
    drive(0, 0, '0, '0, 1, 32'h1111);
    idle(1);

    // 4: timeout, sticky err, later rvalid ignored
    drive(1, 1, 5'd9, 32'h0, 0, '0);
    idle(TIMEOUT);
    idle(2);
    drive(0, 0, '0, '0, 1, 32'h9999);
    idle(1);
    chk("err_sticky", 32'(err), 32'd1);

    // 5: data arrives in the timeout cycle
    do_reset();
    drive(1, 1, 5'd2, 32'h0, 0, '0);
    idle(TIMEOUT - 1);
    drive(0, 0, '0, '0, 1, 32'h1234);
    chk("t5_waddr", 32'(waddr), 32'd2);
    chk("t5_wdata", wdata, 32'h1234);
    idle(1);

    // 6: reset while a load is pending
    drive(1, 1, 5'd6, 32'h0, 0, '0);
    idle(2);
    do_reset();
    drive(0, 0, '0, '0, 1, 32'h6666);
    idle(1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            ASIZE'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 9) == 0, $urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
